// File: rtl/lcd_write_sequencer_pkg.sv
// Shared definitions for the LCD write sequencer: state codes, HD44780
// command bytes, the power-on init ROM and the slow-command classifier.
package lcd_pkg;

   // FSM state codes (plain constants so legacy tools can probe them).
   typedef logic [2:0] state_t;
   localparam state_t ST_PWR_WAIT = 3'd0;
   localparam state_t ST_LOAD     = 3'd1;
   localparam state_t ST_SETUP    = 3'd2;
   localparam state_t ST_EN_HI    = 3'd3;
   localparam state_t ST_HOLD     = 3'd4;
   localparam state_t ST_EXEC     = 3'd5;
   localparam state_t ST_IDLE     = 3'd6;

   // HD44780 command bytes.
   localparam logic [7:0] FUNC_SET = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
   localparam logic [7:0] DISP_ON  = 8'h0C;  // display on, cursor off
   localparam logic [7:0] ENTRY    = 8'h06;  // increment, no shift
   localparam logic [7:0] CLEAR    = 8'h01;
   localparam logic [7:0] HOME     = 8'h02;
   localparam logic [7:0] DDRAM_L1 = 8'h80;
   localparam logic [7:0] DDRAM_L2 = 8'hC0;

   // Index of the final init command.
   localparam logic [2:0] INIT_LAST = 3'd4;

   // NOTE: the init table is a constant function, not a register array, so it
   // needs no reset and synthesises to plain decode logic.
   function automatic logic [7:0] init_rom(input logic [2:0] idx);
      case (idx)
         3'd0:    init_rom = FUNC_SET;
         3'd1:    init_rom = DISP_ON;
         3'd2:    init_rom = ENTRY;
         3'd3:    init_rom = CLEAR;
         3'd4:    init_rom = DDRAM_L1;
         default: init_rom = 8'h00;
      endcase
   endfunction

   // Clear and home need the long execution wait; everything else is short.
   function automatic logic is_slow_cmd(input logic rs, input logic [7:0] db);
      is_slow_cmd = !rs && ((db == CLEAR) || (db == HOME));
   endfunction

endpackage

// File: rtl/lcd_write_sequencer_if.sv
// Write handshake between the scan-code mapper (master) and the LCD write
// sequencer (slave), including the cursor pointer fed back to the mapper.
interface lcd_write_sequencer_if;
   logic       wr_valid;
   logic [7:0] wr_db;
   logic       wr_rs;
   logic       ptr_load;
   logic [4:0] ptr_new;
   logic       wr_ready;
   logic [4:0] pointer;

   modport master (
      output wr_valid, wr_db, wr_rs, ptr_load, ptr_new,
      input  wr_ready, pointer
   );

   modport slave (
      input  wr_valid, wr_db, wr_rs, ptr_load, ptr_new,
      output wr_ready, pointer
   );
endinterface

// File: rtl/lcd_write_sequencer_delay_counter.sv
// Loadable down-counter shared by every timed phase of the sequencer.
// done_o is high while the count sits at zero; a load wins over counting.
module lcd_delay_counter #(
   parameter int CNT_W = 20
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   output logic             done_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Next count: reload, else count down and park at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = load_val_i;
      else if (cnt_q != '0)
         cnt_d = cnt_q - 1'b1;
   end

   // Count register.
   // NOTE: clocked state uses non-blocking assignments so every register in the
   // design samples its inputs from the same edge, independent of block order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign done_o = (cnt_q == '0);

endmodule

// File: rtl/lcd_write_sequencer.sv
// HD44780 write sequencer: runs the power-on init sequence, then accepts one
// {byte, RS} write per handshake, generates setup/EN/hold/exec bus timing and
// owns the cursor pointer read back by the mapper.
module lcd_write_sequencer
   import lcd_pkg::*;
#(
   parameter int T_POWERUP = 750000,
   parameter int T_SETUP   = 2,
   parameter int T_EN      = 12,
   parameter int T_HOLD    = 2,
   parameter int T_EXEC    = 2500,
   parameter int T_CLEAR   = 82000,
   parameter int CNT_W     = 20
) (
   input  logic                 clk,
   input  logic                 rst_n,
   lcd_write_sequencer_if.slave wr,
   output logic                 init_done,
   output logic [7:0]           lcd_db,
   output logic                 lcd_rs,
   output logic                 lcd_rw,
   output logic                 lcd_en
);

   // Counter preload values: a state lasting T cycles is entered with T-1.
   // Power-up spends its first cycle arming the counter, hence T_POWERUP-2.
   localparam logic [CNT_W-1:0] LD_PWR   = CNT_W'((T_POWERUP > 1) ? T_POWERUP - 2 : 0);
   localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP - 1);
   localparam logic [CNT_W-1:0] LD_EN    = CNT_W'(T_EN - 1);
   localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(T_HOLD - 1);
   localparam logic [CNT_W-1:0] LD_EXEC  = CNT_W'(T_EXEC - 1);
   localparam logic [CNT_W-1:0] LD_CLEAR = CNT_W'(T_CLEAR - 1);

   state_t     state_q, state_d;
   logic [2:0] idx_q, idx_d;
   logic       armed_q, armed_d;
   logic       init_done_q, init_done_d;
   logic [7:0] db_q, db_d;
   logic       rs_q, rs_d;
   logic       en_q, en_d;
   logic [4:0] ptr_q, ptr_d;

   logic             cnt_load;
   logic [CNT_W-1:0] cnt_val;
   logic             cnt_done;

   lcd_delay_counter #(.CNT_W(CNT_W)) u_delay (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (cnt_load),
      .load_val_i (cnt_val),
      .done_o     (cnt_done)
   );

   // Sequencer FSM: next state, bus/pointer updates and counter preloads.
   // NOTE: every signal written here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      armed_d     = armed_q;
      init_done_d = init_done_q;
      db_d        = db_q;
      rs_d        = rs_q;
      en_d        = en_q;
      ptr_d       = ptr_q;
      cnt_load    = 1'b0;
      cnt_val     = '0;

      case (state_q)
         ST_PWR_WAIT: begin
            if (!armed_q) begin
               armed_d = 1'b1;
               if (T_POWERUP == 1) begin
                  state_d = ST_LOAD;
               end else begin
                  cnt_load = 1'b1;
                  cnt_val  = LD_PWR;
               end
            end else if (cnt_done) begin
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            db_d     = init_rom(idx_q);
            rs_d     = 1'b0;
            state_d  = ST_SETUP;
            cnt_load = 1'b1;
            cnt_val  = LD_SETUP;
         end
         ST_SETUP: begin
            if (cnt_done) begin
               state_d  = ST_EN_HI;
               en_d     = 1'b1;
               cnt_load = 1'b1;
               cnt_val  = LD_EN;
            end
         end
         ST_EN_HI: begin
            if (cnt_done) begin
               state_d  = ST_HOLD;
               en_d     = 1'b0;
               cnt_load = 1'b1;
               cnt_val  = LD_HOLD;
            end
         end
         ST_HOLD: begin
            if (cnt_done) begin
               state_d  = ST_EXEC;
               cnt_load = 1'b1;
               cnt_val  = is_slow_cmd(rs_q, db_q) ? LD_CLEAR : LD_EXEC;
            end
         end
         ST_EXEC: begin
            if (cnt_done) begin
               if (init_done_q) begin
                  state_d = ST_IDLE;
               end else if (idx_q == INIT_LAST) begin
                  init_done_d = 1'b1;
                  state_d     = ST_IDLE;
               end else begin
                  idx_d   = idx_q + 3'd1;
                  state_d = ST_LOAD;
               end
            end
         end
         ST_IDLE: begin
            if (wr.wr_valid) begin
               db_d     = wr.wr_db;
               rs_d     = wr.wr_rs;
               ptr_d    = wr.ptr_load ? wr.ptr_new : ptr_q + 5'd1;
               state_d  = ST_SETUP;
               cnt_load = 1'b1;
               cnt_val  = LD_SETUP;
            end
         end
         default: state_d = ST_PWR_WAIT;
      endcase
   end

   // State and output registers; reset forces EN low immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_PWR_WAIT;
         idx_q       <= '0;
         armed_q     <= 1'b0;
         init_done_q <= 1'b0;
         db_q        <= '0;
         rs_q        <= 1'b0;
         en_q        <= 1'b0;
         ptr_q       <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         armed_q     <= armed_d;
         init_done_q <= init_done_d;
         db_q        <= db_d;
         rs_q        <= rs_d;
         en_q        <= en_d;
         ptr_q       <= ptr_d;
      end
   end

   assign wr.wr_ready = (state_q == ST_IDLE);
   assign wr.pointer  = ptr_q;
   assign init_done   = init_done_q;
   assign lcd_db      = db_q;
   assign lcd_rs      = rs_q;
   assign lcd_rw      = 1'b0;
   assign lcd_en      = en_q;

endmodule

// File: tb/tb_lcd_write_sequencer.sv
// Self-checking bench for lcd_write_sequencer: init sequence timing, a table of
// directed writes, busy/back-to-back/reset corner cases and random writes
// checked against a timing/pointer reference model.
module tb_lcd_write_sequencer;

   localparam int P = 20;
   localparam int S = 2;
   localparam int E = 3;
   localparam int H = 2;
   localparam int X = 5;
   localparam int C = 9;

   logic       clk;
   logic       rst_n;
   logic       init_done;
   logic [7:0] lcd_db;
   logic       lcd_rs;
   logic       lcd_rw;
   logic       lcd_en;

   lcd_write_sequencer_if wr_if ();

   lcd_write_sequencer #(
      .T_POWERUP (P),
      .T_SETUP   (S),
      .T_EN      (E),
      .T_HOLD    (H),
      .T_EXEC    (X),
      .T_CLEAR   (C),
      .CNT_W     (20)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr        (wr_if),
      .init_done (init_done),
      .lcd_db    (lcd_db),
      .lcd_rs    (lcd_rs),
      .lcd_rw    (lcd_rw),
      .lcd_en    (lcd_en)
   );

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   typedef struct {
      int         rise;
      int         width;
      logic [7:0] db;
      logic       rs;
   } pulse_t;

   pulse_t pulses[$];
   pulse_t cur_pulse;
   logic   en_prev;
   int     stab_err = 0;

   typedef struct {
      logic [7:0] db;
      logic       rs;
      logic       pl;
      logic [4:0] pn;
      logic [4:0] exp_ptr;
      int         exp_busy;
   } vec_t;

   vec_t vecs[8];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Records every EN pulse (rise cycle, width, bus value) and bus changes while EN is high.
   initial begin
      en_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (lcd_en && !en_prev) begin
            cur_pulse.rise  = cyc;
            cur_pulse.width = 1;
            cur_pulse.db    = lcd_db;
            cur_pulse.rs    = lcd_rs;
         end else if (lcd_en) begin
            cur_pulse.width++;
            if (lcd_db !== cur_pulse.db || lcd_rs !== cur_pulse.rs) stab_err++;
         end else if (en_prev) begin
            pulses.push_back(cur_pulse);
         end
         en_prev = lcd_en;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      n_cmp++;
      n_err++;
      $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
   endtask

   task automatic wait_cyc();
      @(negedge clk);
      #1;
   endtask

   // Waits for init_done and checks the five init pulses against the power-up rules.
   task automatic check_init(input string tag, input int r, input bit poke);
      logic [7:0] rom [5];
      int guard, exp_rise, exp_ready, xd;
      bit quiet_ok;
      rom = '{8'h38, 8'h0C, 8'h06, 8'h01, 8'h80};
      if (poke) begin
         wr_if.wr_valid = 1'b1;
         wr_if.wr_db    = 8'h55;
         wr_if.wr_rs    = 1'b1;
         wr_if.ptr_load = 1'b1;
         wr_if.ptr_new  = 5'd9;
      end
      quiet_ok = 1'b1;
      guard    = 0;
      while (!init_done && guard < P + 300) begin
         if (wr_if.wr_ready !== 1'b0 || wr_if.pointer !== 5'd0) quiet_ok = 1'b0;
         wait_cyc();
         guard++;
      end
      wr_if.wr_valid = 1'b0;
      if (!init_done) begin
         timeout({tag, "_done"});
         return;
      end
      exp_rise = r + P + 1 + S;
      check({tag, "_npulses"}, pulses.size(), 5);
      for (int i = 0; i < 5; i++) begin
         xd = (rom[i] == 8'h01 || rom[i] == 8'h02) ? C : X;
         if (i < pulses.size()) begin
            check($sformatf("%s_db%0d", tag, i), pulses[i].db, rom[i]);
            check($sformatf("%s_rs%0d", tag, i), pulses[i].rs, 0);
            check($sformatf("%s_width%0d", tag, i), pulses[i].width, E);
            check($sformatf("%s_rise%0d", tag, i), pulses[i].rise, exp_rise);
         end
         exp_rise = exp_rise + E + H + xd + 1 + S;
      end
      exp_ready = exp_rise - 1 - S;
      check({tag, "_done_cycle"}, cyc, exp_ready);
      check({tag, "_ready_with_done"}, wr_if.wr_ready, 1);
      check({tag, "_ptr"}, wr_if.pointer, 0);
      check({tag, "_quiet"}, quiet_ok, 1);
   endtask

   // One handshake write; checks accept-edge latching, pointer, EN timing and busy length.
   task automatic do_write(input string tag, input logic [7:0] db, input logic rs,
                           input logic pl, input logic [4:0] pn, input logic [4:0] exp_ptr,
                           input int exp_busy, input bit keep_valid,
                           output int acc, output int rdy);
      int guard, n0;
      bit bus_ok, ptr_ok;
      acc = 0;
      rdy = 0;
      wr_if.wr_valid = 1'b1;
      wr_if.wr_db    = db;
      wr_if.wr_rs    = rs;
      wr_if.ptr_load = pl;
      wr_if.ptr_new  = pn;
      guard = 0;
      while (!wr_if.wr_ready && guard < 400) begin
         wait_cyc();
         guard++;
      end
      if (!wr_if.wr_ready) begin
         timeout({tag, "_accept"});
         wr_if.wr_valid = 1'b0;
         return;
      end
      n0 = pulses.size();
      wait_cyc();
      acc = cyc;
      if (!keep_valid) wr_if.wr_valid = 1'b0;
      check({tag, "_ptr"}, wr_if.pointer, exp_ptr);
      check({tag, "_db"}, lcd_db, db);
      check({tag, "_rs"}, lcd_rs, rs);
      check({tag, "_ready_low"}, wr_if.wr_ready, 0);
      bus_ok = 1'b1;
      ptr_ok = 1'b1;
      guard  = 0;
      while (!wr_if.wr_ready && guard < 400) begin
         if (lcd_db !== db || lcd_rs !== rs) bus_ok = 1'b0;
         if (wr_if.pointer !== exp_ptr) ptr_ok = 1'b0;
         wait_cyc();
         guard++;
      end
      if (!wr_if.wr_ready) begin
         timeout({tag, "_ready"});
         return;
      end
      rdy = cyc;
      check({tag, "_busy"}, rdy - acc, exp_busy);
      check({tag, "_bus_stable"}, bus_ok, 1);
      check({tag, "_ptr_hold"}, ptr_ok, 1);
      check({tag, "_npulse"}, pulses.size() - n0, 1);
      if (pulses.size() > n0) begin
         check({tag, "_en_lat"}, pulses[n0].rise - acc, S);
         check({tag, "_en_width"}, pulses[n0].width, E);
         check({tag, "_en_db"}, pulses[n0].db, db);
      end
   endtask

   initial begin
      int r, a, rd, a_prev, rd_prev, n0, guard, gap, exp_busy;
      int p_model;
      logic [7:0] db;
      logic rs, pl;
      logic [4:0] pn, exp_ptr;

      // {db, rs, ptr_load, ptr_new, expected pointer, expected accept-to-ready}
      vecs[0] = '{8'h61, 1'b1, 1'b0, 5'd0,  5'd1,  S + E + H + X};
      vecs[1] = '{8'h01, 1'b0, 1'b0, 5'd0,  5'd2,  S + E + H + C};
      vecs[2] = '{8'h02, 1'b0, 1'b0, 5'd0,  5'd3,  S + E + H + C};
      vecs[3] = '{8'h01, 1'b1, 1'b0, 5'd0,  5'd4,  S + E + H + X};
      vecs[4] = '{8'h41, 1'b1, 1'b1, 5'd31, 5'd31, S + E + H + X};
      vecs[5] = '{8'h42, 1'b1, 1'b0, 5'd0,  5'd0,  S + E + H + X};
      vecs[6] = '{8'hC0, 1'b0, 1'b1, 5'd17, 5'd17, S + E + H + X};
      vecs[7] = '{8'h80, 1'b0, 1'b0, 5'd0,  5'd18, S + E + H + X};

      rst_n          = 1'b0;
      wr_if.wr_valid = 1'b0;
      wr_if.wr_db    = 8'h00;
      wr_if.wr_rs    = 1'b0;
      wr_if.ptr_load = 1'b0;
      wr_if.ptr_new  = 5'd0;
      repeat (3) wait_cyc();

      check("rst_en", lcd_en, 0);
      check("rst_db", lcd_db, 0);
      check("rst_rs", lcd_rs, 0);
      check("rst_rw", lcd_rw, 0);
      check("rst_ready", wr_if.wr_ready, 0);
      check("rst_ptr", wr_if.pointer, 0);
      check("rst_done", init_done, 0);

      rst_n = 1'b1;
      r = cyc;
      check_init("init1", r, 1'b1);

      // Directed table.
      for (int i = 0; i < 8; i++) begin
         do_write($sformatf("vec%0d", i), vecs[i].db, vecs[i].rs, vecs[i].pl, vecs[i].pn,
                  vecs[i].exp_ptr, vecs[i].exp_busy, 1'b0, a, rd);
      end

      // Clear command with the next request held during busy, then three back-to-back writes.
      n0 = pulses.size();
      do_write("busy_clr", 8'h01, 1'b0, 1'b0, 5'd0, 5'd19, S + E + H + C, 1'b1, a_prev, rd_prev);
      do_write("b2b0", 8'h31, 1'b1, 1'b0, 5'd0, 5'd20, S + E + H + X, 1'b1, a, rd);
      check("b2b0_immediate", a, rd_prev + 1);
      rd_prev = rd;
      do_write("b2b1", 8'h32, 1'b1, 1'b0, 5'd0, 5'd21, S + E + H + X, 1'b1, a, rd);
      check("b2b1_immediate", a, rd_prev + 1);
      rd_prev = rd;
      do_write("b2b2", 8'h33, 1'b1, 1'b0, 5'd0, 5'd22, S + E + H + X, 1'b0, a, rd);
      check("b2b2_immediate", a, rd_prev + 1);
      check("b2b_pulses", pulses.size() - n0, 4);
      wait_cyc();
      check("b2b_no_extra", wr_if.wr_ready, 1);

      // Reset asserted while EN is high during a data write.
      wr_if.wr_valid = 1'b1;
      wr_if.wr_db    = 8'h5A;
      wr_if.wr_rs    = 1'b1;
      wr_if.ptr_load = 1'b0;
      wait_cyc();
      wr_if.wr_valid = 1'b0;
      check("rstmid_ptr", wr_if.pointer, 23);
      guard = 0;
      while (!lcd_en && guard < 50) begin
         wait_cyc();
         guard++;
      end
      if (!lcd_en) timeout("rstmid_en");
      #2 rst_n = 1'b0;
      #1;
      check("rstmid_en_low", lcd_en, 0);
      check("rstmid_ptr_zero", wr_if.pointer, 0);
      check("rstmid_ready", wr_if.wr_ready, 0);
      check("rstmid_done", init_done, 0);
      wait_cyc();
      pulses.delete();
      rst_n = 1'b1;
      r = cyc;
      check_init("init2", r, 1'b0);

      // Random writes against the reference model.
      p_model = 0;
      for (int i = 0; i < 40; i++) begin
         db = 8'($urandom);
         rs = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 3) == 0) begin
            rs = 1'b0;
            db = ($urandom_range(0, 1) == 1) ? 8'h01 : 8'h02;
         end
         pl = ($urandom_range(0, 3) == 0);
         pn = 5'($urandom);
         p_model  = pl ? int'(pn) : (p_model + 1) % 32;
         exp_ptr  = 5'(p_model);
         exp_busy = S + E + H + ((rs == 1'b0 && (db == 8'h01 || db == 8'h02)) ? C : X);
         gap = $urandom_range(0, 2);
         repeat (gap) wait_cyc();
         do_write($sformatf("rnd%0d", i), db, rs, pl, pn, exp_ptr, exp_busy, 1'b0, a, rd);
      end

      check("bus_change_while_en", stab_err, 0);
      check("rw_const", lcd_rw, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/lcd_write_sequencer.md
Name: lcd_write_sequencer

Overview:
- Downstream stage of the scan-code-to-ASCII mapper.
- Accepts one {data byte, RS} write per handshake and owns the cursor pointer register that the mapper reads back.
- Generates HD44780-compatible bus timing (setup, EN pulse, hold, execution wait).
- Runs the power-on init sequence autonomously before accepting any write.

Parameters:
- T_POWERUP, 750000, cycles to wait after reset before the first init command (15 ms @ 50 MHz).
- T_SETUP, 2, cycles that RS/DB are stable before EN rises.
- T_EN, 12, cycles EN is held high.
- T_HOLD, 2, cycles that RS/DB are held after EN falls.
- T_EXEC, 2500, post-write wait for normal commands and data (50 us).
- T_CLEAR, 82000, post-write wait when RS=0 and DB is 8'h01 or 8'h02 (1.64 ms).
- CNT_W, 20, width of the shared delay counter; must hold the largest T_*.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- wr_valid  in  1  write request; held high until accepted.
- wr_db  in  8  byte to write (mapper lcd_dbOut).
- wr_rs  in  1  register select (mapper rsOut): 0 = command, 1 = data.
- ptr_load  in  1  mapper pointer_changed; sampled only on accept.
- ptr_new  in  5  mapper new_pointer; sampled only on accept.
- wr_ready  out  1  high only in IDLE; a transfer occurs when wr_valid && wr_ready on a rising clk.
- pointer  out  5  cursor pointer, fed back to the mapper.
- init_done  out  1  sticky high once the init sequence completes.
- lcd_db  out  8  LCD data bus.
- lcd_rs  out  1  LCD register select.
- lcd_rw  out  1  constant 0 (write-only).
- lcd_en  out  1  LCD enable strobe.

Behaviour:
- Reset values: lcd_en=0, lcd_rs=0, lcd_rw=0, lcd_db=8'h00, wr_ready=0, pointer=0, init_done=0, state=PWR_WAIT, init index=0, counter=0.
- Reset asserted mid-operation: lcd_en drops immediately (asynchronous); the full init sequence reruns after release.
- States: PWR_WAIT, LOAD, SETUP, EN_HI, HOLD, EXEC, IDLE.
- PWR_WAIT: count T_POWERUP cycles -> LOAD.
- LOAD (init phase):
  - Drive init ROM entry [idx] with RS=0: 8'h38, 8'h0C, 8'h06, 8'h01, 8'h80.
  - -> SETUP.
- SETUP: T_SETUP cycles, EN=0 -> EN_HI.
- EN_HI: EN=1 for exactly T_EN cycles -> HOLD.
- HOLD: EN=0, bus unchanged, T_HOLD cycles -> EXEC.
- EXEC: wait T_CLEAR if the byte was a command 8'h01 or 8'h02, else T_EXEC. Then:
  - idx<4: idx++ -> LOAD.
  - idx==4: init_done=1 -> IDLE.
  - post-init: -> IDLE.
- IDLE: wr_ready=1. On accept:
  - Latch wr_db/wr_rs onto lcd_db/lcd_rs in the same edge; wr_ready falls next cycle.
  - Pointer update on the same edge: if ptr_load, pointer<=ptr_new; else pointer<=pointer+1 (5-bit, 31 wraps to 0).
  - -> SETUP.
- Each counted state occupies exactly its T_* cycles (counter preloaded on entry, exit at terminal count). Consequences:
  - Accept-to-EN-rise latency = T_SETUP cycles.
  - Accept-to-next-wr_ready = T_SETUP+T_EN+T_HOLD+T_EXEC/T_CLEAR cycles.
- wr_valid while wr_ready=0: ignored, no pointer change; upstream holds the request.
- pointer is not modified during init.
- lcd_db/lcd_rs change only on accept or LOAD, never while EN=1.
- Parameters of 0 are illegal; a single cycle is the minimum.

Decomposition:
- Package lcd_pkg:
  - State enum.
  - Init ROM constants (FUNC_SET 8'h38, DISP_ON 8'h0C, ENTRY 8'h06, CLEAR 8'h01, HOME 8'h02, DDRAM_L1 8'h80, DDRAM_L2 8'hC0).
  - Helper function is_slow_cmd(rs, db).
- One sub-module, lcd_delay_counter: loadable down-counter with a done flag. The FSM stays in the top module.

Test Plan (bench uses T_POWERUP=20, T_SETUP=2, T_EN=3, T_HOLD=2, T_EXEC=5, T_CLEAR=9):
- Reset release -> after 20 cycles, five EN pulses of 3 cycles with DB 38,0C,06,01,80, all RS=0. The gap after 01 reflects T_CLEAR. init_done and wr_ready rise together; pointer=0.
- After init, write db=8'h61 rs=1 ptr_load=0 -> lcd_db=61, rs=1; EN rises 2 cycles after accept; pointer 0->1; wr_ready returns 12 cycles after accept.
- pointer=31, data write with ptr_load=0 -> pointer=0 (wrap). Then write db=C0 rs=0 ptr_load=1 ptr_new=17 -> pointer=17, EXEC lasts 5 cycles.
- Command db=01 rs=0 -> EXEC lasts 9 cycles; wr_valid asserted during busy is not accepted and pointer is unchanged until wr_ready.
- rst_n low during EN_HI of a data write -> lcd_en=0 and pointer=0 immediately; init sequence restarts from PWR_WAIT.
- Back-to-back wr_valid held continuously for 3 writes -> exactly 3 EN pulses; DB stable from SETUP through HOLD each time.
